// File: rtl/psubsb_seq_pkg.sv
// Shared types and constants for the packed 4x4-bit signed subtractor sequencer.
package psubsb_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [3:0] SAT_POS = 4'b0111;
    localparam logic [3:0] SAT_NEG = 4'b1000;

    // Clamp value for an overflowing lane; the sign of the minuend picks the rail.
    function automatic logic [3:0] lane_sat(input logic neg);
        return neg ? SAT_NEG : SAT_POS;
    endfunction

endpackage

// File: rtl/psubsb_seq_add_4b.sv
// 4-bit adder cell with carry-in; the carry-out is not needed by any user.
module add_4b (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       cin_i,
    output logic [3:0] sum_o
);

    assign sum_o = a_i + b_i + {3'b000, cin_i};

endmodule

// File: rtl/psubsb_seq.sv
// Sequential packed subtractor: four signed 4-bit lanes processed one per cycle
// through a single shared adder, with optional per-lane saturation.
//
// state | meaning
// IDLE  | waiting for an operand pair, in_ready high
// BUSY  | one lane computed and written per cycle, lanes 0..3
// DONE  | result presented, held until out_ready
module psubsb_seq
    import psubsb_seq_pkg::*;
#(
    parameter int SAT_EN = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] s,
    output logic [3:0]  v,
    output logic        busy
);

    state_e      state_q, state_d;
    logic [1:0]  lane_q;
    logic [15:0] a_q, b_q, s_q;
    logic [3:0]  v_q;

    logic        accept;
    logic [3:0]  a_lane, b_lane, diff, lane_res;
    logic        ovf;

    assign accept = in_valid && in_ready;
    assign a_lane = a_q[{lane_q, 2'b00} +: 4];
    assign b_lane = b_q[{lane_q, 2'b00} +: 4];

    // a - b as a + ~b + 1 on the one shared lane adder
    add_4b u_add (
        .a_i   (a_lane),
        .b_i   (~b_lane),
        .cin_i (1'b1),
        .sum_o (diff)
    );

    assign ovf      = (a_lane[3] != b_lane[3]) && (diff[3] != a_lane[3]);
    assign lane_res = ((SAT_EN != 0) && ovf) ? lane_sat(a_lane[3]) : diff;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = BUSY;
            BUSY:    if (lane_q == 2'd3) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state_q)
            IDLE:    in_ready = 1'b1;
            BUSY:    busy = 1'b1;
            DONE:    begin
                out_valid = 1'b1;
                busy      = 1'b1;
            end
            default: busy = 1'b1;
        endcase
    end

    // Result registers move only on accept (clear) and on BUSY lane writes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lane_q <= 2'd0;
            a_q    <= 16'h0000;
            b_q    <= 16'h0000;
            s_q    <= 16'h0000;
            v_q    <= 4'h0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        a_q    <= a;
                        b_q    <= b;
                        lane_q <= 2'd0;
                        s_q    <= 16'h0000;
                        v_q    <= 4'h0;
                    end
                end
                BUSY: begin
                    s_q[{lane_q, 2'b00} +: 4] <= lane_res;
                    v_q[lane_q]               <= ovf;
                    lane_q                    <= lane_q + 2'd1;
                end
                default: ;
            endcase
        end
    end

    assign s = s_q;
    assign v = v_q;

endmodule

// File: tb/tb_psubsb_seq.sv
// Scoreboard bench: a saturating and a wrapping instance driven in lockstep,
// checked against an integer-arithmetic lane model.
module tb_psubsb_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] a_in, b_in;
    logic        out_ready;

    logic        in_ready1, out_valid1, busy1;
    logic [15:0] s1;
    logic [3:0]  v1;
    logic        in_ready0, out_valid0, busy0;
    logic [15:0] s0;
    logic [3:0]  v0;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        logic [15:0] s1;
        logic [3:0]  v1;
        logic [15:0] s0;
        logic [3:0]  v0;
        int          acc_cyc;
    } exp_t;

    exp_t exp_q[$];

    psubsb_seq #(.SAT_EN(1)) dut_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
        .a(a_in), .b(b_in), .out_valid(out_valid1), .out_ready(out_ready),
        .s(s1), .v(v1), .busy(busy1)
    );

    psubsb_seq #(.SAT_EN(0)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
        .a(a_in), .b(b_in), .out_valid(out_valid0), .out_ready(out_ready),
        .s(s0), .v(v0), .busy(busy0)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Reference: true signed difference per lane, then clamp or wrap to 4 bits.
    function automatic logic [19:0] model(input logic [15:0] av, input logic [15:0] bv, input bit sat);
        logic [15:0] rs;
        logic [3:0]  rv;
        int          ai, bi, d;
        logic [31:0] dv;
        rs = '0;
        rv = '0;
        for (int i = 0; i < 4; i++) begin
            ai = int'($signed(av[i*4 +: 4]));
            bi = int'($signed(bv[i*4 +: 4]));
            d  = ai - bi;
            if (d > 7 || d < -8) begin
                rv[i] = 1'b1;
                if (sat) d = (d > 7) ? 7 : -8;
            end
            dv = d;
            rs[i*4 +: 4] = dv[3:0];
        end
        return {rv, rs};
    endfunction

    always @(posedge clk) begin
        if (rst_n && in_valid && in_ready1) begin
            exp_t e;
            logic [19:0] m1, m0;
            m1 = model(a_in, b_in, 1'b1);
            m0 = model(a_in, b_in, 1'b0);
            e.s1 = m1[15:0];
            e.v1 = m1[19:16];
            e.s0 = m0[15:0];
            e.v0 = m0[19:16];
            e.acc_cyc = cyc;
            exp_q.push_back(e);
        end
    end

    logic        ov_prev = 1'b0;
    logic [15:0] hold_s1, hold_s0;
    logic [3:0]  hold_v1, hold_v0;

    always @(negedge clk) begin
        if (rst_n && out_valid1 && !ov_prev) begin
            check("valid_lockstep", {31'd0, out_valid0}, 32'd1);
            if (exp_q.size() == 0) begin
                check("unexpected_result", 32'd0, 32'd1);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("s_sat", {16'd0, s1}, {16'd0, e.s1});
                check("v_sat", {28'd0, v1}, {28'd0, e.v1});
                check("s_wrap", {16'd0, s0}, {16'd0, e.s0});
                check("v_wrap", {28'd0, v0}, {28'd0, e.v0});
                check("latency", cyc - e.acc_cyc - 1, 32'd4);
            end
            hold_s1 = s1; hold_v1 = v1; hold_s0 = s0; hold_v0 = v0;
        end else if (rst_n && out_valid1 && ov_prev) begin
            check("hold_s_sat", {16'd0, s1}, {16'd0, hold_s1});
            check("hold_v_sat", {28'd0, v1}, {28'd0, hold_v1});
            check("hold_s_wrap", {16'd0, s0}, {16'd0, hold_s0});
            check("hold_v_wrap", {28'd0, v0}, {28'd0, hold_v0});
        end
        ov_prev = rst_n && out_valid1;
    end

    task automatic check_idle(input string tag);
        check({tag, "_out_valid"}, {31'd0, out_valid1}, 32'd0);
        check({tag, "_s"}, {16'd0, s1}, 32'd0);
        check({tag, "_v"}, {28'd0, v1}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy1}, 32'd0);
        check({tag, "_in_ready"}, {31'd0, in_ready1}, 32'd1);
        check({tag, "_s_wrap"}, {16'd0, s0}, 32'd0);
    endtask

    // Present one operand pair; returns at the negedge after the accepting edge.
    task automatic send(input logic [15:0] av, input logic [15:0] bv);
        for (int t = 0; t < 20 && !in_ready1; t++) @(negedge clk);
        check("send_ready_timeout", {31'd0, in_ready1}, 32'd1);
        in_valid = 1'b1;
        a_in = av;
        b_in = bv;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic finish_op(input int stall, input bit poke);
        for (int t = 0; t < 20 && !out_valid1; t++) @(negedge clk);
        check("done_timeout", {31'd0, out_valid1}, 32'd1);
        for (int k = 0; k < stall; k++) begin
            check("stall_in_ready", {31'd0, in_ready1}, 32'd0);
            check("stall_out_valid", {31'd0, out_valid1}, 32'd1);
            if (poke) begin
                in_valid = 1'b1;
                a_in = $urandom;
                b_in = $urandom;
            end
            @(negedge clk);
            in_valid = 1'b0;
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("after_done_out_valid", {31'd0, out_valid1}, 32'd0);
        check("after_done_in_ready", {31'd0, in_ready1}, 32'd1);
        check("after_done_busy", {31'd0, busy1}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        a_in = '0;
        b_in = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_idle("reset");
        rst_n = 1'b1;

        send(16'h1234, 16'h0111);
        finish_op(0, 1'b0);
        send(16'h7008, 16'hF001);
        finish_op(1, 1'b0);
        send(16'h0000, 16'h8888);
        finish_op(0, 1'b0);

        // Backpressure with ignored operand pulses in BUSY and DONE
        send(16'h5A3C, 16'h2B7F);
        in_valid = 1'b1;
        a_in = 16'hFFFF;
        b_in = 16'h0000;
        @(negedge clk);
        in_valid = 1'b0;
        finish_op(3, 1'b1);

        // Reset while lane 2 is about to be written
        send(16'h7777, 16'h8888);
        repeat (2) @(negedge clk);
        check("pre_reset_busy", {31'd0, busy1}, 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check_idle("mid_reset");
        exp_q.delete();
        rst_n = 1'b1;
        send(16'h8421, 16'h1248);
        finish_op(2, 1'b0);

        for (int n = 0; n < 40; n++) begin
            send(16'($urandom), 16'($urandom));
            finish_op(int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)));
        end

        repeat (3) @(negedge clk);
        check("queue_drained", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/psubsb_seq.md
PSUBSB_SEQ -- requirements
Module: psubsb_seq

Interface
REQ-001 SHALL have one parameter: SAT_EN, default 1, 1 = saturate overflowing lanes, 0 = wrap-around (overflow still flagged).
REQ-002 SHALL use one clock; reset is synchronous and active-low.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst_n  input  1  synchronous active-low reset.
REQ-005 in_valid  input  1  operand pair a/b present.
REQ-006 in_ready  output  1  block can accept operands.
REQ-007 a  input  16  minuend, four signed 4-bit lanes, lane0 = [3:0] ... lane3 = [15:12].
REQ-008 b  input  16  subtrahend, same lane layout.
REQ-009 out_valid  output  1  s/v hold a completed result.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 s  output  16  packed per-lane a-b result.
REQ-012 v  output  4  per-lane signed overflow flag, bit i = lane i.
REQ-013 busy  output  1  high in any state other than IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-015 IDLE: in_ready=1; on in_valid&&in_ready latch a, b, clear lane counter, clear s and v, go to BUSY.
REQ-016 BUSY: in_ready=0; each cycle compute one lane (index = 2-bit lane counter), write its 4 result bits into s and its flag into v, then increment the counter.
REQ-017 BUSY SHALL last exactly 4 cycles, lanes in order 0,1,2,3; after writing lane 3, go to DONE.
REQ-018 Latency: operands accepted at edge k; out_valid=1 after edge k+4.
REQ-019 DONE: out_valid=1; s and v SHALL be held stable while out_ready=0.
REQ-020 In DONE with out_ready=1, return to IDLE; in_ready=1 in the following cycle, with no same-cycle accept.
REQ-021 Lane arithmetic: diff = a_i + ~b_i + 1, 4-bit, carry-out discarded.
REQ-022 Overflow: v_i = (a_i[3] != b_i[3]) && (diff[3] != a_i[3]).
REQ-023 SAT_EN=1 and v_i=1: lane result SHALL be 4'b0111 if a_i[3]=0, else 4'b1000.
REQ-024 SAT_EN=0, or v_i=0: lane result SHALL be diff.
REQ-025 b_i = 4'b1000 with a_i >= 0 SHALL flag overflow and saturate to 0111 (SAT_EN=1).
REQ-026 in_valid in BUSY or DONE SHALL be ignored; operands are not latched.
REQ-027 s and v SHALL change only in IDLE->BUSY (clear) and BUSY lane writes.

Reset
REQ-028 rst_n=0 at a rising edge SHALL force state=IDLE, lane counter=0, s=16'h0000, v=4'h0, out_valid=0, busy=0, in_ready=1 after that edge.
REQ-029 Reset asserted mid-BUSY or in DONE SHALL abandon the operation; no partial result is ever presented.

Structure
REQ-030 The shared package SHALL hold the state enum (IDLE/BUSY/DONE) and the constants SAT_POS=4'b0111 and SAT_NEG=4'b1000, also used by the packed-add saturation path.
REQ-031 The existing add_4b cell SHALL be instantiated once as the single lane subtractor (b inverted, cin=1'b1), time-shared across lanes through the lane-select mux.

Verification
REQ-032 a=16'h1234, b=16'h0111, SAT_EN=1 -> s=16'h1123, v=4'b0000, out_valid high exactly 4 edges after accept.
REQ-033 a=16'h7008, b=16'hF001, SAT_EN=1 -> s=16'h7008, v=4'b1001.
REQ-034 Same operands, SAT_EN=0 -> s=16'h8007, v=4'b1001.
REQ-035 a=16'h0000, b=16'h8888, SAT_EN=1 -> s=16'h7777, v=4'b1111.
REQ-036 Backpressure: out_ready=0 for 3 cycles in DONE -> s/v/out_valid stable, in_ready=0; in_valid pulses during BUSY/DONE not latched; out_ready=1 -> IDLE next cycle.
REQ-037 rst_n=0 during BUSY lane 2 -> next cycle out_valid=0, s=0, v=0, busy=0, in_ready=1; a following op completes normally.
